// File: rtl/ext_bus_master.sv
// ext_bus_master
//   CPU-side initiator for an 8-bit multiplexed external memory bus on the
//   chip's bidirectional IO pins. One CPU load/store becomes the sequence:
//   address phase (ALE), optional turnaround (reads), data phase with
//   four-phase ack handshake, release.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : data phases abort after TIMEOUT_CYCLES cycles without ack,
//               cpu_err is set (sticky until the next accepted request) and
//               a timed-out read returns 8'hFF.
//   Undefined : no timeout counter, data phases wait forever, cpu_err = 0.
//
// Parameters
//   ALE_CYCLES     : cycles the address phase is held (>= 1)
//   TIMEOUT_CYCLES : data-phase wait limit, 1..255 (BUS_TIMEOUT_EN only)
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   cpu_req       : request strobe, sampled only while cpu_busy = 0
//   cpu_we        : 1 = write, 0 = read
//   cpu_addr      : target address
//   cpu_wdata     : write data
//   cpu_busy      : transaction in progress
//   cpu_done      : one-cycle completion pulse (first IDLE cycle)
//   cpu_rdata     : last read data (held across writes and idle)
//   cpu_err       : last transaction timed out (sticky)
//   bus_in        : pin input path
//   bus_out       : pin output path
//   bus_oe        : per-pin output enable, 1 = drive
//   bus_ale       : address latch enable
//   bus_rd        : read strobe
//   bus_wr        : write strobe
//   bus_ack       : responder acknowledge
//
// Handshake: the CPU side is a request/busy pair -- a request is accepted
// on the edge where cpu_req = 1 and cpu_busy = 0; completion is the single
// cpu_done pulse. The bus side is four-phase: strobe rises, responder
// raises bus_ack, strobe falls, responder drops bus_ack before the master
// may return to IDLE.
//
// All outputs are registered: next-state logic computes the following
// state and the outputs that state presents, and both are loaded together.

module ext_bus_master #(
  parameter int ALE_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_busy,
  output logic       cpu_done,
  output logic [7:0] cpu_rdata,
  output logic       cpu_err,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  output logic       bus_ale,
  output logic       bus_rd,
  output logic       bus_wr,
  input  logic       bus_ack
);

  // Elaboration-time guard: an illegal parameter set instantiates a module
  // that does not exist, so the build fails instead of misbehaving.
  generate
    if (ALE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      ext_bus_master_illegal_parameter u_bad_param ();
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_TURN  = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_REL   = 3'd5
  } state_t;

  localparam int ALE_W = (ALE_CYCLES > 1) ? $clog2(ALE_CYCLES) : 1;
  localparam logic [ALE_W-1:0] ALE_LAST = ALE_W'(ALE_CYCLES - 1);

  state_t           state, state_n;
  logic [ALE_W-1:0] ale_cnt, ale_cnt_n;
  logic             we_q, we_n;
  logic [7:0]       addr_q, addr_n;
  logic [7:0]       wdata_q, wdata_n;

  logic [7:0]       rdata_n;
  logic             done_n;
  logic             busy_n;
  logic [7:0]       out_n;
  logic [7:0]       oe_n;
  logic             ale_n;
  logic             rd_n;
  logic             wr_n;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       err_q;
  logic       err_set;
  logic       err_clr;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    ale_cnt_n = ale_cnt;
    we_n      = we_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    rdata_n   = cpu_rdata;
    done_n    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_n = tmo_cnt;
    err_set   = 1'b0;
    err_clr   = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          we_n      = cpu_we;
          addr_n    = cpu_addr;
          wdata_n   = cpu_wdata;
          ale_cnt_n = '0;
          state_n   = S_ADDR;
`ifdef BUS_TIMEOUT_EN
          err_clr   = 1'b1;
`endif
        end
      end

      S_ADDR: begin
        if (ale_cnt == ALE_LAST) begin
          state_n = we_q ? S_WDATA : S_TURN;
`ifdef BUS_TIMEOUT_EN
          tmo_cnt_n = '0;
`endif
        end else begin
          ale_cnt_n = ale_cnt + 1'b1;
        end
      end

      // One dead cycle so the responder never drives against our address.
      S_TURN: begin
        state_n = S_RDATA;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_n = '0;
`endif
      end

      S_WDATA: begin
        if (bus_ack) begin
          state_n = S_REL;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_n = S_REL;
          err_set = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
`endif
      end

      S_RDATA: begin
        if (bus_ack) begin
          rdata_n = bus_in;
          state_n = S_REL;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          rdata_n = 8'hFF;
          state_n = S_REL;
          err_set = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
`endif
      end

      // Wait for the responder to drop ack (also after a timeout).
      S_REL: begin
        if (!bus_ack) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Outputs presented by the state being entered.
    out_n  = 8'h00;
    oe_n   = 8'h00;
    ale_n  = 1'b0;
    rd_n   = 1'b0;
    wr_n   = 1'b0;
    busy_n = (state_n != S_IDLE);

    case (state_n)
      S_ADDR: begin
        out_n = addr_n;
        oe_n  = 8'hFF;
        ale_n = 1'b1;
      end
      S_WDATA: begin
        out_n = wdata_n;
        oe_n  = 8'hFF;
        wr_n  = 1'b1;
      end
      S_RDATA: begin
        rd_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ale_cnt   <= '0;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= 8'h00;
      bus_out   <= 8'h00;
      bus_oe    <= 8'h00;
      bus_ale   <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
    end else begin
      state     <= state_n;
      ale_cnt   <= ale_cnt_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      cpu_busy  <= busy_n;
      cpu_done  <= done_n;
      cpu_rdata <= rdata_n;
      bus_out   <= out_n;
      bus_oe    <= oe_n;
      bus_ale   <= ale_n;
      bus_rd    <= rd_n;
      bus_wr    <= wr_n;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cpu_err = err_q;
`else
  assign cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_bus_master.sv
// tb_ext_bus_master
//   Directed bench for ext_bus_master (ALE_CYCLES = 1, TIMEOUT_CYCLES = 4).
//   Inputs change 1 time unit after the rising edge and outputs are checked
//   at that same point, so each tick() lands in the next registered state.
//   Background monitors count done pulses, ALE cycles and any cycle with
//   the pins driven while the read strobe is high.

module tb_ext_bus_master;

  logic       clk;
  logic       rst;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_busy;
  logic       cpu_done;
  logic [7:0] cpu_rdata;
  logic       cpu_err;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic [7:0] bus_oe;
  logic       bus_ale;
  logic       bus_rd;
  logic       bus_wr;
  logic       bus_ack;

  int n_checks;
  int n_pass;
  int done_seen;
  int ale_seen;
  int oe_rd_overlap;
  int exp_done;
  int exp_ale;

  logic [7:0] exp_q[$];

  ext_bus_master #(
    .ALE_CYCLES     (1),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_ale   (bus_ale),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_ack   (bus_ack)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors
  always @(negedge clk) begin
    if (cpu_done) done_seen++;
    if (bus_ale) ale_seen++;
    if (bus_rd && (bus_oe != 8'h00)) oe_rd_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_oe"},   32'(bus_oe),   32'h00);
    check({tag, "_out"},  32'(bus_out),  32'h00);
    check({tag, "_ale"},  32'(bus_ale),  32'h0);
    check({tag, "_rd"},   32'(bus_rd),   32'h0);
    check({tag, "_wr"},   32'(bus_wr),   32'h0);
    check({tag, "_busy"}, 32'(cpu_busy), 32'h0);
    check({tag, "_done"}, 32'(cpu_done), 32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    done_seen     = 0;
    ale_seen      = 0;
    oe_rd_overlap = 0;
    exp_done      = 0;
    exp_ale       = 0;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    bus_in    = 8'h00;
    bus_ack   = 1'b0;

    // Reset, then 5 idle cycles
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_idle_outputs("rst");
    check("rst_rdata", 32'(cpu_rdata), 32'h00);
    check("rst_err",   32'(cpu_err),   32'h0);

    // Write 3C <- A5, ack one cycle after wr rises
    issue(1'b1, 8'h3C, 8'hA5);
    exp_ale++;
    tick();
    cpu_req = 1'b0;
    check("w_addr_ale",  32'(bus_ale),  32'h1);
    check("w_addr_out",  32'(bus_out),  32'h3C);
    check("w_addr_oe",   32'(bus_oe),   32'hFF);
    check("w_addr_busy", 32'(cpu_busy), 32'h1);
    check("w_addr_wr",   32'(bus_wr),   32'h0);
    tick();
    check("w_data_wr",  32'(bus_wr),  32'h1);
    check("w_data_out", 32'(bus_out), 32'hA5);
    check("w_data_oe",  32'(bus_oe),  32'hFF);
    check("w_data_ale", 32'(bus_ale), 32'h0);
    // Request while busy must be dropped
    issue(1'b0, 8'h99, 8'h00);
    tick();
    cpu_req = 1'b0;
    check("w_wait_wr", 32'(bus_wr), 32'h1);
    bus_ack = 1'b1;
    tick();
    check("w_rel_wr",   32'(bus_wr),   32'h0);
    check("w_rel_oe",   32'(bus_oe),   32'h00);
    check("w_rel_busy", 32'(cpu_busy), 32'h1);
    check("w_rel_done", 32'(cpu_done), 32'h0);
    tick();
    check("w_rel2_busy", 32'(cpu_busy), 32'h1);
    bus_ack = 1'b0;
    tick();
    exp_done++;
    check("w_done",       32'(cpu_done),  32'h1);
    check("w_done_busy",  32'(cpu_busy),  32'h0);
    check("w_done_rdata", 32'(cpu_rdata), 32'h00);

    // Back-to-back read of 10 on the done cycle; responder acks late
    issue(1'b0, 8'h10, 8'h00);
    exp_q.push_back(8'h5A);
    exp_ale++;
    tick();
    cpu_req = 1'b0;
    check("r_addr_ale",  32'(bus_ale),  32'h1);
    check("r_addr_out",  32'(bus_out),  32'h10);
    check("r_addr_oe",   32'(bus_oe),   32'hFF);
    check("r_addr_done", 32'(cpu_done), 32'h0);
    tick();
    check("r_turn_oe",   32'(bus_oe),   32'h00);
    check("r_turn_rd",   32'(bus_rd),   32'h0);
    check("r_turn_ale",  32'(bus_ale),  32'h0);
    check("r_turn_busy", 32'(cpu_busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_data_rd", 32'(bus_rd), 32'h1);
      check("r_data_oe", 32'(bus_oe), 32'h00);
    end
    bus_ack = 1'b1;
    bus_in  = 8'h5A;
    tick();
    check("r_rel_rd",    32'(bus_rd),    32'h0);
    check("r_rel_rdata", 32'(cpu_rdata), 32'h5A);
    check("r_rel_done",  32'(cpu_done),  32'h0);
    bus_ack = 1'b0;
    bus_in  = 8'h00;
    tick();
    exp_done++;
    check("r_done", 32'(cpu_done), 32'h1);
    if (exp_q.size() > 0) begin
      check("r_done_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
    end else begin
      check("r_exp_q_empty", 32'(exp_q.size()), 32'h1);
    end
    tick();
    check("r_done_pulse", 32'(cpu_done),  32'h0);
    check("r_rdata_hold", 32'(cpu_rdata), 32'h5A);

    // Reset during RDATA
    issue(1'b0, 8'h77, 8'h00);
    exp_ale++;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    check("x_rdata_rd", 32'(bus_rd), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("x_rst");
    check("x_rst_rdata", 32'(cpu_rdata), 32'h00);
    tick();
    check("x_after_done", 32'(cpu_done), 32'h0);

    // Write after reset, immediate responder
    issue(1'b1, 8'h01, 8'h02);
    exp_ale++;
    tick();
    cpu_req = 1'b0;
    check("w2_addr_out", 32'(bus_out), 32'h01);
    tick();
    check("w2_data_out", 32'(bus_out), 32'h02);
    bus_ack = 1'b1;
    tick();
    check("w2_rel_wr", 32'(bus_wr), 32'h0);
    bus_ack = 1'b0;
    tick();
    exp_done++;
    check("w2_done",       32'(cpu_done),  32'h1);
    check("w2_done_rdata", 32'(cpu_rdata), 32'h00);
    check("w2_err",        32'(cpu_err),   32'h0);

`ifdef BUS_TIMEOUT_EN
    // Read with no ack: four RDATA cycles then abort
    tick();
    issue(1'b0, 8'h20, 8'h00);
    exp_ale++;
    tick();
    cpu_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t_data_rd", 32'(bus_rd), 32'h1);
    end
    tick();
    check("t_rel_rd",    32'(bus_rd),    32'h0);
    check("t_rel_err",   32'(cpu_err),   32'h1);
    check("t_rel_rdata", 32'(cpu_rdata), 32'hFF);
    check("t_rel_done",  32'(cpu_done),  32'h0);
    tick();
    exp_done++;
    check("t_done",      32'(cpu_done), 32'h1);
    check("t_done_err",  32'(cpu_err),  32'h1);
    tick();
    check("t_err_sticky", 32'(cpu_err), 32'h1);
    issue(1'b1, 8'h30, 8'h31);
    exp_ale++;
    tick();
    cpu_req = 1'b0;
    check("t_err_clr", 32'(cpu_err), 32'h0);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    exp_done++;
    check("t2_done",  32'(cpu_done),  32'h1);
    check("t2_rdata", 32'(cpu_rdata), 32'hFF);
`endif

    tick();
    tick();
    check("end_idle_busy",   32'(cpu_busy),      32'h0);
    check("done_pulses",     32'(done_seen),     32'(exp_done));
    check("ale_cycles",      32'(ale_seen),      32'(exp_ale));
    check("oe_during_rd",    32'(oe_rd_overlap), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
